// File: rtl/snd_tone_gen_pkg.sv
// rtl/snd_tone_gen_pkg.sv - shared tone generator types; SND_SYNC_RELOAD_EN selects boundary-aligned reload
package snd_tone_gen_pkg;
   localparam int SND_COUNT_W = 26;

   typedef enum logic {
      SND_SILENT = 1'b0,
      SND_RUN    = 1'b1
   } snd_state_t;

`ifdef SND_SYNC_RELOAD_EN
   localparam bit SND_SYNC_RELOAD = 1'b1;
`else
   localparam bit SND_SYNC_RELOAD = 1'b0;
`endif
endpackage

// File: rtl/snd_divider.sv
// rtl/snd_divider.sv - half-period counter, boundary compare and square-wave toggle (reload timing from SND_SYNC_RELOAD_EN)
module snd_divider
   import snd_tone_gen_pkg::*;
#(
   parameter int COUNT_W = SND_COUNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               reload_req,
   input  logic               reload_zero,
   input  logic [COUNT_W-1:0] active_max,
   output logic               reload_ack,
   output logic               snd_out
);
   logic [COUNT_W-1:0] counter_q, counter_d;
   logic               out_q, out_d;
   logic               boundary;

   always_comb begin
      boundary   = (counter_q == active_max - COUNT_W'(1));
      // Synchronous reload waits for the half-period to finish; otherwise it is taken at once.
      reload_ack = reload_req && (boundary || !SND_SYNC_RELOAD);
      counter_d  = counter_q + COUNT_W'(1);
      out_d      = out_q;
      if (clear || (reload_ack && reload_zero)) begin
         counter_d = '0;
         out_d     = 1'b0;
      end else if (reload_ack && !SND_SYNC_RELOAD) begin
         counter_d = '0;
      end else if (boundary) begin
         counter_d = '0;
         out_d     = ~out_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         counter_q <= '0;
         out_q     <= 1'b0;
      end else begin
         counter_q <= counter_d;
         out_q     <= out_d;
      end
   end

   assign snd_out = out_q;
endmodule

// File: rtl/snd_tone_gen.sv
// rtl/snd_tone_gen.sv - latched-count square-wave tone generator; SND_SYNC_RELOAD_EN selects boundary-aligned reload
module snd_tone_gen
   import snd_tone_gen_pkg::*;
#(
   parameter int COUNT_W = SND_COUNT_W
) (
   input  logic               clk,
   input  logic               rst_async,
   input  logic [COUNT_W-1:0] snd_max_count,
   input  logic               snd_latch_max_count,
   output logic               snd_out,
   output logic               snd_active,
   output logic               snd_reload_pending
);
   snd_state_t         state_q, state_d;
   logic [COUNT_W-1:0] pending_max_q, pending_max_d;
   logic               pending_valid_q, pending_valid_d;
   logic [COUNT_W-1:0] active_max_q, active_max_d;
   logic               div_clear, reload_req, reload_zero, reload_ack, consume;

   always_ff @(posedge clk or negedge rst_async) begin
      if (!rst_async) begin
         state_q         <= SND_SILENT;
         pending_max_q   <= '0;
         pending_valid_q <= 1'b0;
         active_max_q    <= '0;
      end else begin
         state_q         <= state_d;
         pending_max_q   <= pending_max_d;
         pending_valid_q <= pending_valid_d;
         active_max_q    <= active_max_d;
      end
   end

   always_comb begin
      consume = ((state_q == SND_SILENT) && pending_valid_q) || reload_ack;
      state_d = state_q;
      case (state_q)
         SND_SILENT: if (pending_valid_q && !reload_zero) state_d = SND_RUN;
         SND_RUN:    if (reload_ack && reload_zero)       state_d = SND_SILENT;
         default:    state_d = SND_SILENT;
      endcase
      // A fresh capture always wins over a consume on the same edge.
      pending_max_d   = snd_latch_max_count ? snd_max_count : pending_max_q;
      pending_valid_d = snd_latch_max_count || (pending_valid_q && !consume);
      active_max_d    = consume ? pending_max_q : active_max_q;
   end

   always_comb begin
      div_clear          = (state_q == SND_SILENT);
      reload_req         = (state_q == SND_RUN) && pending_valid_q;
      reload_zero        = (pending_max_q == '0);
      snd_active         = (state_q == SND_RUN);
      snd_reload_pending = pending_valid_q;
   end

   snd_divider #(.COUNT_W(COUNT_W)) u_divider (
      .clk         (clk),
      .rst_n       (rst_async),
      .clear       (div_clear),
      .reload_req  (reload_req),
      .reload_zero (reload_zero),
      .active_max  (active_max_q),
      .reload_ack  (reload_ack),
      .snd_out     (snd_out)
   );
endmodule
